solver_readout: RTL and testbench
=================================

Name: solver_readout

Overview:
- Reads per-pixel iteration counts back out of the multi_solver result memories through its rd_solver_id/rd_addr read port.
- Emits them as a raster-ordered pixel stream with valid/ready handshake and x/y coordinates, for the framebuffer/VGA writer.
- Pixel k lives in solver (k mod NUM_SOLVERS) at address (k div NUM_SOLVERS).
- Started once the solver array reports done.

Parameters:
- NUM_SOLVERS, 11, number of solver instances interleaved across pixels
- ID_WIDTH, 6, width of rd_solver_id
- ADDR_WIDTH, 19, width of rd_addr and num_pixels
- DATA_WIDTH, 8, width of one iteration count
- COORD_WIDTH, 10, width of width/out_x/out_y

Ports:
- clock  in  1  system clock; all state on its rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle pulse; begins a readout when idle
- width  in  COORD_WIDTH  image width in pixels, sampled at start
- num_pixels  in  ADDR_WIDTH  total pixel count, sampled at start
- rd_solver_id  out  ID_WIDTH  solver select for result read
- rd_addr  out  ADDR_WIDTH  word address within selected solver
- rd_data  in  DATA_WIDTH  result word, valid exactly 1 cycle after id/addr presented
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  DATA_WIDTH  iteration count
- out_x  out  COORD_WIDTH  pixel column
- out_y  out  COORD_WIDTH  pixel row
- out_last  out  1  high with the final pixel
- busy  out  1  readout in progress
- done  out  1  level; high after final pixel accepted until next start

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters 0; FIFO empty. rd_solver_id=0, rd_addr=0, out_valid=0, out_data/out_x/out_y=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on start; latch width (0 treated as 1) and num_pixels; clear counters; done=0.
  - num_pixels=0 at start: go IDLE->DONE directly, no reads, no output.
  - RUN->DRAIN when issued count reaches num_pixels.
  - DRAIN->DONE when the final pixel is accepted.
  - DONE->RUN on start; otherwise hold.
  - start in RUN/DRAIN is ignored.
- busy=1 in RUN and DRAIN only.
- Issue side: read issued in a cycle iff state==RUN, issued<num_pixels, and (FIFO occupancy + reads in flight) < 2. Ensures returning data always has a slot; no data is lost.
- On issue: rd_solver_id increments; at NUM_SOLVERS-1 it wraps to 0 and rd_addr increments. Counters only, no divider.
- rd_solver_id/rd_addr hold value when not issuing.
- Return side: a read issued in cycle t writes rd_data into a 2-entry FIFO at t+1.
- Output: out_valid = FIFO non-empty; out_data = FIFO head. out_x/out_y/out_last are registered with the head.
- out_x increments per accepted pixel, wrapping at width-1 to 0 with out_y+1.
- out_last=1 iff head index == num_pixels-1.
- Sustained throughput: 1 pixel/cycle with out_ready held high. First out_valid 2 cycles after start.
- out_valid, once high, stays high with stable data/x/y/last until accepted.
- Simultaneous FIFO push and pop keeps occupancy constant.
- Reset mid-operation aborts immediately to reset state; in-flight read discarded.

Test Plan:
- NUM_SOLVERS=11, width=4, num_pixels=12, out_ready=1 -> reads (0,0),(1,0)..(10,0),(0,1); 12 outputs, x 0..3, y 0..2; out_last on pixel 11; done=1 one cycle after.
- Same run, out_ready toggling 1,0,0,1… -> no drops or duplicates; data/x/y stable while stalled; never more than 2 reads outstanding+buffered.
- num_pixels=0, start -> no rd issue, out_valid never 1, done=1 next cycle, busy stays 0.
- Start pulse during RUN with num_pixels=20 -> ignored; exactly 20 outputs.
- Assert reset (low) at pixel 5 of 12 -> all outputs return to reset values immediately; a new start replays from pixel 0.
- width=1, num_pixels=3 -> out_x always 0, out_y 0,1,2.

Source files
------------

// File: rtl/solver_readout.sv
// rtl/solver_readout.sv - raster-order readout of interleaved solver result memories
// Issues reads at most two ahead of the consumer so every returning word has a FIFO slot.
module solver_readout #(
  parameter int NUM_SOLVERS = 11,
  parameter int ID_WIDTH    = 6,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] width,
  input  logic [ADDR_WIDTH-1:0]  num_pixels,
  output logic [ID_WIDTH-1:0]    rd_solver_id,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_SOLVERS - 1);

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] width_q, width_d;
  logic [ADDR_WIDTH-1:0]  num_q, num_d;
  logic [ADDR_WIDTH-1:0]  issued_q, issued_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]  fifo_q [2];
  logic [DATA_WIDTH-1:0]  fifo_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    num_d      = num_q;
    issued_d   = issued_q;
    id_d       = id_q;
    addr_d     = addr_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    last_d     = last_q;
    busy_d     = busy_q;
    done_d     = done_q;

    pop  = (cnt_q != 2'd0) && out_ready;
    push = inflight_q;
    // A slot freed by this cycle's pop may be reused, which sustains one pixel per cycle.
    occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = (state_q == RUN) && (issued_q < num_q) && (occ < 3'd2);

    inflight_d = issue;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      issued_d = issued_q + ADDR_WIDTH'(1);
      if (id_q == LAST_ID) begin
        id_d   = '0;
        addr_d = addr_q + ADDR_WIDTH'(1);
      end else begin
        id_d = id_q + ID_WIDTH'(1);
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = rd_data;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      idx_d    = idx_q + ADDR_WIDTH'(1);
      last_d   = ((idx_q + ADDR_WIDTH'(1)) == (num_q - ADDR_WIDTH'(1)));
      if (x_q == width_q - COORD_WIDTH'(1)) begin
        x_d = '0;
        y_d = y_q + COORD_WIDTH'(1);
      end else begin
        x_d = x_q + COORD_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          width_d  = (width == '0) ? COORD_WIDTH'(1) : width;
          num_d    = num_pixels;
          issued_d = '0;
          id_d     = '0;
          addr_d   = '0;
          x_d      = '0;
          y_d      = '0;
          idx_d    = '0;
          last_d   = (num_pixels == ADDR_WIDTH'(1));
          if (num_pixels == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      RUN: begin
        if (issue && (issued_q + ADDR_WIDTH'(1) == num_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      width_q    <= COORD_WIDTH'(1);
      num_q      <= '0;
      issued_q   <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_solver_id = id_q;
  assign rd_addr      = addr_q;
  assign out_valid    = (cnt_q != 2'd0);
  assign out_data     = fifo_q[rd_ptr_q];
  assign out_x        = x_q;
  assign out_y        = y_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_solver_readout.sv
// tb/tb_solver_readout.sv - scoreboard bench for solver_readout
// Result memories are modelled by a fixed function of (solver id, address).
module tb_solver_readout;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  width = '0;
  logic [18:0] num_pixels = '0;
  logic [5:0]  rd_solver_id;
  logic [18:0] rd_addr;
  logic [7:0]  rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic        out_last;
  logic        busy;
  logic        done;

  solver_readout dut (
    .clock(clock), .reset(reset), .start(start), .width(width), .num_pixels(num_pixels),
    .rd_solver_id(rd_solver_id), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_val(input logic [5:0] id, input logic [18:0] a);
    logic [7:0] t;
    t = {2'b00, id} * 8'd37 + a[7:0] * 8'd11 + 8'd5;
    return t;
  endfunction

  always @(posedge clock) rd_data <= mem_val(rd_solver_id, rd_addr);

  typedef struct {
    logic [7:0] d;
    logic [9:0] x;
    logic [9:0] y;
    logic       last;
  } exp_t;

  typedef struct {
    int w;
    int n;
    int mode;
    int lx;
    int ly;
  } vec_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_iss = 0;
  int max_out = 0;
  int cyc = 0;
  int ready_mode = 0;
  int last_x = 0;
  int last_y = 0;
  bit mon_en = 0;
  bit iss_en = 0;
  bit done_chk = 0;
  bit stall_prev = 0;
  logic [3:0]  pat = 4'b1001;
  logic [5:0]  prev_id;
  logic [18:0] prev_addr;
  logic [7:0]  h_d;
  logic [9:0]  h_x, h_y;
  logic        h_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_expected(input int w, input int n);
    int we;
    exp_t e;
    we = (w == 0) ? 1 : w;
    for (int k = 0; k < n; k++) begin
      e.d    = mem_val(6'(k % 11), 19'(k / 11));
      e.x    = 10'(k % we);
      e.y    = 10'(k / we);
      e.last = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat[cyc[1:0]];
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (mon_en) begin
      if (iss_en && {rd_solver_id, rd_addr} != {prev_id, prev_addr}) n_iss++;
      prev_id   = rd_solver_id;
      prev_addr = rd_addr;
      if (n_iss - n_acc > max_out) max_out = n_iss - n_acc;
      if (done_chk) begin
        chk("done_after_last", {31'd0, done}, 32'd1);
        chk("busy_after_last", {31'd0, busy}, 32'd0);
        done_chk = 0;
      end
      if (stall_prev) begin
        chk("stall_hold", {out_valid, out_data, out_x, out_y, out_last},
            {1'b1, h_d, h_x, h_y, h_l});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pixel", {out_data, out_x, out_y, out_last}, {e.d, e.x, e.y, e.last});
          n_acc++;
          last_x = int'(out_x);
          last_y = int'(out_y);
          if (out_last) done_chk = 1;
        end
      end
      stall_prev = out_valid && !out_ready;
      h_d = out_data; h_x = out_x; h_y = out_y; h_l = out_last;
    end
  end

  task automatic pulse_start(input int w, input int n);
    @(negedge clock);
    #2;
    width = 10'(w);
    num_pixels = 19'(n);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (!(done === 1'b1 && sb.size() == 0) && t < 3000) begin
      @(negedge clock);
      #3;
      t++;
    end
    chk({nm, "_timeout"}, {31'd0, (t < 3000)}, 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic begin_run(input int w, input int n, input int mode);
    ready_mode = mode;
    sb.delete();
    push_expected(w, n);
    n_acc = 0; n_iss = 0; max_out = 0;
    stall_prev = 0; done_chk = 0; iss_en = 0;
    mon_en = 1;
    pulse_start(w, n);
    prev_id = rd_solver_id;
    prev_addr = rd_addr;
    iss_en = 1;
  endtask

  task automatic end_run(input string nm, input int n);
    wait_done(nm);
    chk({nm, "_count"}, 32'(n_acc), 32'(n));
    chk({nm, "_issues"}, 32'(n_iss), 32'(n));
    chk({nm, "_outstanding"}, {31'd0, (max_out <= 2)}, 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    bit any_valid;
    vecs[0] = '{w: 4, n: 12, mode: 0, lx: 3, ly: 2};
    vecs[1] = '{w: 4, n: 12, mode: 1, lx: 3, ly: 2};
    vecs[2] = '{w: 1, n: 3,  mode: 0, lx: 0, ly: 2};
    vecs[3] = '{w: 0, n: 5,  mode: 2, lx: 0, ly: 4};
    vecs[4] = '{w: 3, n: 1,  mode: 0, lx: 0, ly: 0};
    vecs[5] = '{w: 7, n: 30, mode: 2, lx: 1, ly: 4};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {rd_solver_id, rd_addr, out_valid, out_data, out_x, out_y, out_last, busy, done},
        '0);
    @(negedge clock);
    reset = 1'b1;

    // Zero-pixel start: straight to done, nothing read or emitted.
    pulse_start(4, 0);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    any_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      any_valid |= out_valid | busy;
      if ({rd_solver_id, rd_addr} != '0) any_valid = 1;
    end
    chk("zero_quiet", {31'd0, any_valid}, 32'd0);

    // First-pixel latency and first read addresses.
    begin_run(4, 12, 0);
    chk("lat_valid_c0", {31'd0, out_valid}, 32'd0);
    chk("lat_busy", {30'd0, busy, done}, 32'd2);
    @(posedge clock); #1;
    chk("lat_valid_c1", {31'd0, out_valid}, 32'd0);
    chk("rd_second", {rd_solver_id, rd_addr}, {6'd1, 19'd0});
    @(posedge clock); #1;
    chk("lat_valid_c2", {31'd0, out_valid}, 32'd1);
    end_run("lat", 12);

    for (int v = 0; v < 6; v++) begin
      begin_run(vecs[v].w, vecs[v].n, vecs[v].mode);
      end_run($sformatf("vec%0d", v), vecs[v].n);
      chk($sformatf("vec%0d_last_xy", v), {16'(last_x), 16'(last_y)},
          {16'(vecs[v].lx), 16'(vecs[v].ly)});
    end

    // Second start while running is ignored.
    begin_run(5, 20, 1);
    repeat (4) @(negedge clock);
    #2;
    width = 10'd2; num_pixels = 19'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    end_run("restart_ignored", 20);

    // Reset part-way through, then replay from pixel 0.
    begin_run(4, 12, 0);
    begin
      int t;
      t = 0;
      while (n_acc < 5 && t < 200) begin
        @(negedge clock);
        t++;
      end
      chk("midreset_reach", {31'd0, (t < 200)}, 32'd1);
    end
    #2;
    mon_en = 0; iss_en = 0; stall_prev = 0; done_chk = 0;
    reset = 1'b0;
    #1;
    chk("midreset_outputs", {rd_solver_id, rd_addr, out_valid, out_data, out_x, out_y, out_last, busy, done},
        '0);
    sb.delete();
    @(negedge clock);
    #2;
    reset = 1'b1;
    begin_run(4, 12, 2);
    end_run("replay", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
